// File: rtl/button_pkg.sv
// Shared types and parameter floors for the push-button input stage.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  // Smallest usable values; anything lower would give zero-width counters
  // or back-to-back step pulses.
  localparam int unsigned DB_CYCLES_MIN     = 2;
  localparam int unsigned REPEAT_DELAY_MIN  = 2;
  localparam int unsigned REPEAT_PERIOD_MIN = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a push-button; emits one step per accepted press
// plus optional auto-repeat pulses while the button stays held.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic rpt_en,
  output logic btn_level,
  output logic step
);

  localparam int unsigned DB_EFF = max_u(DB_CYCLES, DB_CYCLES_MIN);
  localparam int unsigned RD_EFF = max_u(REPEAT_DELAY, REPEAT_DELAY_MIN);
  localparam int unsigned RP_EFF = max_u(REPEAT_PERIOD, REPEAT_PERIOD_MIN);
  localparam int unsigned DB_W   = $clog2(DB_EFF);
  localparam int unsigned RPT_W  = $clog2(max_u(RD_EFF, RP_EFF));

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_EFF - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(RD_EFF - 1);
  localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(RP_EFF - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic s;

  db_state_e        state, state_next;
  logic [DB_W-1:0]  db_cnt, db_cnt_next;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic [RPT_W-1:0] rpt_target;
  logic             rpt_phase, rpt_phase_next;
  logic             btn_level_next;
  logic             step_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  always_comb begin
    state_next     = state;
    db_cnt_next    = db_cnt;
    rpt_cnt_next   = '0;
    rpt_phase_next = 1'b0;
    step_next      = 1'b0;
    rpt_target     = rpt_phase ? RP_LAST : RD_LAST;

    case (state)
      RELEASED: begin
        if (s) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = DB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = HELD;
          db_cnt_next = '0;
          step_next   = 1'b1;
        end else if (db_cnt != '1) begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_next  = REL_WAIT;
          db_cnt_next = DB_ONE;
        end else if (rpt_en) begin
          // First pulse waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          if (rpt_cnt == rpt_target) begin
            step_next      = 1'b1;
            rpt_cnt_next   = '0;
            rpt_phase_next = 1'b1;
          end else begin
            rpt_cnt_next   = (rpt_cnt != '1) ? rpt_cnt + RPT_ONE : rpt_cnt;
            rpt_phase_next = rpt_phase;
          end
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_next  = HELD;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else if (db_cnt != '1) begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_next  = RELEASED;
        db_cnt_next = '0;
      end
    endcase

    btn_level_next = (state_next == HELD) || (state_next == REL_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RELEASED;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
      btn_level <= 1'b0;
      step      <= 1'b0;
    end else begin
      state     <= state_next;
      db_cnt    <= db_cnt_next;
      rpt_cnt   <= rpt_cnt_next;
      rpt_phase <= rpt_phase_next;
      btn_level <= btn_level_next;
      step      <= step_next;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and random checks of button_debouncer against a run-length model.
module tb_button_debouncer;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic rpt_en;
  logic btn_level;
  logic step;

  always #5 clk = ~clk;

  button_debouncer #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .rpt_en    (rpt_en),
    .btn_level (btn_level),
    .step      (step)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: s is btn_in two edges late; the level flips after DB consecutive
  // samples of s disagreeing with it; repeats count held-and-enabled edges.
  bit m_h1, m_h2, m_level, m_step, m_phase;
  int m_run, m_since;

  bit prev_step, prev_level;
  int fall_cyc;
  int sq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_step = 0; m_phase = 0;
    m_run = 0; m_since = 0;
  endtask

  task automatic model_edge();
    bit s_now, held;
    s_now = m_h2;
    m_h2  = m_h1;
    m_h1  = btn_in;
    held  = m_level && (m_run == 0);
    m_step = 0;
    if (held && s_now && rpt_en) begin
      m_since++;
      if (m_since == (m_phase ? RP : RD)) begin
        m_step  = 1;
        m_since = 0;
        m_phase = 1;
      end
    end else begin
      m_since = 0;
      m_phase = 0;
    end
    if (s_now != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = s_now;
        m_run   = 0;
        if (s_now) m_step = 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("level", {31'b0, btn_level}, {31'b0, m_level});
    check("step", {31'b0, step}, {31'b0, m_step});
    check("step_gap", {31'b0, step & prev_step}, 32'd0);
    if (step) sq.push_back(cyc);
    if (prev_level && !btn_level) fall_cyc = cyc;
    prev_step  = step;
    prev_level = btn_level;
  endtask

  int k0, t0, len, nexp;
  bit pat [6] = '{1, 1, 0, 1, 1, 0};
  bit rpat [3] = '{0, 0, 1};

  initial begin
    rst = 1'b1; btn_in = 1'b0; rpt_en = 1'b0;
    prev_step = 0; prev_level = 0; fall_cyc = -1;
    model_reset();
    #12;
    check("reset_level", {31'b0, btn_level}, 32'd0);
    check("reset_step", {31'b0, step}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Clean press
    sq.delete();
    btn_in = 1'b1;
    k0 = cyc + 1;
    repeat (8) tick();
    check("clean_nsteps", sq.size(), 32'd1);
    if (sq.size() > 0) check("clean_step_edge", sq[0], k0 + DB + 1);
    btn_in = 1'b0;
    repeat (8) tick();

    // Press bounce
    sq.delete();
    k0 = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      btn_in = pat[i];
      tick();
    end
    btn_in = 1'b1;
    repeat (10) tick();
    check("bounce_nsteps", sq.size(), 32'd1);
    if (sq.size() > 0) check("bounce_step_edge", sq[0], k0 + 6 + DB + 1);

    // Release bounce
    sq.delete();
    fall_cyc = -1;
    k0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      btn_in = rpat[i];
      tick();
    end
    btn_in = 1'b0;
    repeat (10) tick();
    check("relbounce_fall_edge", fall_cyc, k0 + 3 + DB + 1);
    check("relbounce_nsteps", sq.size(), 32'd0);

    // Auto-repeat
    sq.delete();
    rpt_en = 1'b1;
    btn_in = 1'b1;
    k0 = cyc + 1;
    t0 = k0 + DB + 1;
    repeat (DB + 1 + 30) tick();
    nexp = 1;
    for (int t = t0 + RD; t <= cyc; t += RP) nexp++;
    check("rpt_nsteps", sq.size(), nexp);
    if (sq.size() > 0) check("rpt_press", sq[0], t0);
    for (int i = 1; i < sq.size() && i < nexp; i++)
      check("rpt_edge", sq[i], t0 + RD + (i - 1) * RP);
    btn_in = 1'b0;
    rpt_en = 1'b0;
    repeat (8) tick();

    // Reset mid-press (PRESS_WAIT, count 3)
    btn_in = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_level", {31'b0, btn_level}, 32'd0);
    check("midrst_step", {31'b0, step}, 32'd0);
    model_reset();
    prev_step = 0; prev_level = 0;
    #2;
    rst = 1'b0;
    sq.delete();
    k0 = cyc + 1;
    repeat (10) tick();
    check("midrst_nsteps", sq.size(), 32'd1);
    if (sq.size() > 0) check("midrst_step_edge", sq[0], k0 + DB + 1);
    btn_in = 1'b0;
    repeat (8) tick();

    // rpt_en dropped for one cycle at repeat count 8
    rpt_en = 1'b1;
    btn_in = 1'b1;
    sq.delete();
    repeat (DB + 2) tick();
    check("drop_press", sq.size(), 32'd1);
    t0 = cyc;
    repeat (8) tick();
    rpt_en = 1'b0;
    tick();
    rpt_en = 1'b1;
    sq.delete();
    while (cyc < t0 + 25) tick();
    check("drop_nsteps", sq.size(), 32'd3);
    if (sq.size() > 0) check("drop_first", sq[0], t0 + 9 + RD);
    if (sq.size() > 1) check("drop_second", sq[1], t0 + 9 + RD + RP);
    btn_in = 1'b0;
    rpt_en = 1'b0;
    repeat (8) tick();

    // Random segments against the model
    for (int seg = 0; seg < 250; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rpt_en = ~rpt_en;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      repeat (len) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
